// File: rtl/exec_pkg.sv
// Shared types and default sizing for the registered execute stage.
// Holds the opcode and FSM enums plus the lane constants derived from them.
package exec_pkg;

  localparam int DATAW_D = 32;
  localparam int PCW_D   = 32;
  localparam int IMMW_D  = 11;
  localparam int LANEW_D = 8;
  localparam int NPRED_D = 4;

  localparam int NLANES = DATAW_D / LANEW_D;
  localparam int LSELW  = (NLANES > 1) ? $clog2(NLANES) : 1;

  typedef enum logic [2:0] {
    OP_ADD   = 3'd0,
    OP_INC   = 3'd1,
    OP_SUB   = 3'd2,
    OP_LDI   = 3'd3,
    OP_CMPGT = 3'd4,
    OP_CMPNZ = 3'd5,
    OP_MUL   = 3'd6,
    OP_RSVD  = 3'd7
  } op_e;

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_MUL_BUSY = 2'd1,
    S_MUL_DONE = 2'd2
  } state_e;

endpackage

// File: rtl/exec_mul_iter.sv
// Shift-add multiplier retiring one multiplier bit per clock.
// Ports: clk, rst, kill, start, a, b -> busy, done (last step), product.
module exec_mul_iter #(
  parameter int DATAW = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             kill,
  input  logic             start,
  input  logic [DATAW-1:0] a,
  input  logic [DATAW-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [DATAW-1:0] product
);

  localparam int CW = $clog2(DATAW + 1);

  logic [DATAW-1:0] ma;
  logic [DATAW-1:0] mb;
  logic [DATAW-1:0] acc;
  logic [CW-1:0]    cnt;

  // done flags the edge that performs the final iteration
  assign done    = busy && (cnt == CW'(DATAW - 1));
  assign product = acc;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ma   <= '0;
      mb   <= '0;
      acc  <= '0;
      cnt  <= '0;
      busy <= 1'b0;
    end else if (kill) begin
      cnt  <= '0;
      busy <= 1'b0;
    end else if (start) begin
      ma   <= a;
      mb   <= b;
      acc  <= '0;
      cnt  <= '0;
      busy <= 1'b1;
    end else if (busy) begin
      if (mb[0])
        acc <= acc + ma;
      ma <= ma << 1;
      mb <= mb >> 1;
      if (done) begin
        cnt  <= '0;
        busy <= 1'b0;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/execute_pipe.sv
// Registered execute stage with valid/ready handshake, flush and predicates.
// In: op/a/b/imm/lane_sel/pc_in/branch/pred sels; out: ex_out, pc_out, taken.
module execute_pipe
  import exec_pkg::*;
#(
  parameter int DATAW = DATAW_D,
  parameter int PCW   = PCW_D,
  parameter int IMMW  = IMMW_D,
  parameter int LANEW = LANEW_D,
  parameter int NPRED = NPRED_D
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            flush,
  input  logic                            in_valid,
  output logic                            in_ready,
  input  op_e                             op,
  input  logic [DATAW-1:0]                a,
  input  logic [DATAW-1:0]                b,
  input  logic [IMMW-1:0]                 imm,
  input  logic [$clog2(DATAW/LANEW)-1:0]  lane_sel,
  input  logic [PCW-1:0]                  pc_in,
  input  logic                            branch_in,
  input  logic [$clog2(NPRED)-1:0]        pred_rd_sel,
  input  logic [$clog2(NPRED)-1:0]        pred_wr_sel,
  input  logic                            pred_wr_en,
  output logic                            out_valid,
  input  logic                            out_ready,
  output logic [DATAW-1:0]                ex_out,
  output logic [PCW-1:0]                  pc_out,
  output logic                            branch_taken,
  output logic [NPRED-1:0]                pred_out
);

  state_e           state;
  state_e           state_nxt;
  logic [NPRED-1:0] pred;
  logic [PCW-1:0]   mul_pc;
  logic             mul_taken;
  logic             accept;
  logic             is_mul;
  logic             is_cmp;
  logic             out_free;
  logic             flag;
  logic [DATAW-1:0] sum;
  logic [DATAW-1:0] res;
  logic [PCW-1:0]   pc_calc;
  logic             taken_calc;
  logic             mul_busy;
  logic             mul_done;
  logic [DATAW-1:0] mul_prod;

  assign out_free = !out_valid || out_ready;
  assign in_ready = (state == S_IDLE) && out_free && !flush && !mul_busy;
  assign accept   = in_valid && in_ready;
  assign is_mul   = (op == OP_MUL);
  assign is_cmp   = (op == OP_CMPGT) || (op == OP_CMPNZ);
  assign pred_out = pred;

  assign sum        = a + b;
  assign pc_calc    = pc_in + {{(PCW-IMMW){imm[IMMW-1]}}, imm};
  assign taken_calc = branch_in && pred[pred_rd_sel];

  always_comb begin
    flag = 1'b0;
    res  = '0;
    unique case (op)
      OP_ADD:   res = sum;
      OP_INC:   res = a + 1'b1;
      OP_SUB:   res = a - b;
      OP_LDI: begin
        res = a;
        res[int'(lane_sel)*LANEW +: LANEW] = imm[LANEW-1:0];
      end
      OP_CMPGT: begin
        flag = (a > b);
        res  = {{(DATAW-1){1'b0}}, flag};
      end
      OP_CMPNZ: begin
        flag = (sum != '0);
        res  = {{(DATAW-1){1'b0}}, flag};
      end
      default:  res = '0;
    endcase
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      S_IDLE:     if (accept && is_mul) state_nxt = S_MUL_BUSY;
      S_MUL_BUSY: if (mul_done) state_nxt = S_MUL_DONE;
      S_MUL_DONE: if (out_free) state_nxt = S_IDLE;
      default:    state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= S_IDLE;
      out_valid    <= 1'b0;
      ex_out       <= '0;
      pc_out       <= '0;
      branch_taken <= 1'b0;
      pred         <= '0;
      mul_pc       <= '0;
      mul_taken    <= 1'b0;
    end else if (flush) begin
      state     <= S_IDLE;
      out_valid <= 1'b0;
    end else begin
      state <= state_nxt;
      if (accept && !is_mul) begin
        out_valid    <= 1'b1;
        ex_out       <= res;
        pc_out       <= pc_calc;
        branch_taken <= taken_calc;
      end else if (accept) begin
        // old result (if any) drains on this edge; mul result comes later
        out_valid <= 1'b0;
        mul_pc    <= pc_calc;
        mul_taken <= taken_calc;
      end else if (state == S_MUL_DONE && out_free) begin
        out_valid    <= 1'b1;
        ex_out       <= mul_prod;
        pc_out       <= mul_pc;
        branch_taken <= mul_taken;
      end else if (out_valid && out_ready) begin
        out_valid <= 1'b0;
      end
      if (accept && is_cmp && pred_wr_en)
        pred[pred_wr_sel] <= flag;
    end
  end

  exec_mul_iter #(
    .DATAW (DATAW)
  ) u_mul (
    .clk     (clk),
    .rst     (rst),
    .kill    (flush),
    .start   (accept && is_mul),
    .a       (a),
    .b       (b),
    .busy    (mul_busy),
    .done    (mul_done),
    .product (mul_prod)
  );

endmodule

// File: tb/tb_execute_pipe.sv
// Directed bench for execute_pipe: ALU ops, predicates, mul, stall, flush.
// Prints one summary line with test and failure counts.
module tb_execute_pipe;
  import exec_pkg::*;

  logic             clk = 1'b0;
  logic             rst;
  logic             flush;
  logic             in_valid;
  logic             in_ready;
  op_e              op;
  logic [31:0]      a;
  logic [31:0]      b;
  logic [10:0]      imm;
  logic [LSELW-1:0] lane_sel;
  logic [31:0]      pc_in;
  logic             branch_in;
  logic [1:0]       pred_rd_sel;
  logic [1:0]       pred_wr_sel;
  logic             pred_wr_en;
  logic             out_valid;
  logic             out_ready;
  logic [31:0]      ex_out;
  logic [31:0]      pc_out;
  logic             branch_taken;
  logic [3:0]       pred_out;

  int tests = 0;
  int fails = 0;
  int n;
  int nr;

  always #5 clk = ~clk;

  execute_pipe dut (
    .clk          (clk),
    .rst          (rst),
    .flush        (flush),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .op           (op),
    .a            (a),
    .b            (b),
    .imm          (imm),
    .lane_sel     (lane_sel),
    .pc_in        (pc_in),
    .branch_in    (branch_in),
    .pred_rd_sel  (pred_rd_sel),
    .pred_wr_sel  (pred_wr_sel),
    .pred_wr_en   (pred_wr_en),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .ex_out       (ex_out),
    .pc_out       (pc_out),
    .branch_taken (branch_taken),
    .pred_out     (pred_out)
  );

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input op_e o, input logic [31:0] va,
                       input logic [31:0] vb);
    in_valid = 1'b1;
    op       = o;
    a        = va;
    b        = vb;
  endtask

  initial begin
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; op = OP_ADD;
    a = '0; b = '0; imm = '0; lane_sel = '0; pc_in = '0;
    branch_in = 1'b0; pred_rd_sel = '0; pred_wr_sel = '0;
    pred_wr_en = 1'b0; out_ready = 1'b1;
    #1;
    chk("rst_valid", out_valid, 0);
    chk("rst_ex", ex_out, 0);
    chk("rst_pc", pc_out, 0);
    chk("rst_taken", branch_taken, 0);
    chk("rst_pred", pred_out, 0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    #1;
    chk("idle_ready", in_ready, 1);

    issue(OP_ADD, 32'hFFFF_FFFF, 32'd2);
    step();
    chk("add_valid", out_valid, 1);
    chk("add_ex", ex_out, 32'h1);
    issue(OP_INC, 32'd5, 32'd0);
    step();
    chk("inc_valid", out_valid, 1);
    chk("inc_ex", ex_out, 32'd6);

    issue(OP_LDI, 32'h1122_3344, 32'd0);
    imm = 11'h0AB; lane_sel = 2; pc_in = 32'h100;
    step();
    chk("ldi_ex", ex_out, 32'h11AB_3344);
    chk("ldi_pc", pc_out, 32'h1AB);
    issue(OP_ADD, 32'd0, 32'd0);
    imm = 11'h7FF;
    step();
    chk("pc_neg", pc_out, 32'hFF);

    issue(OP_CMPGT, 32'd9, 32'd3);
    imm = '0; pc_in = '0;
    pred_wr_sel = 1; pred_wr_en = 1'b1; branch_in = 1'b1; pred_rd_sel = 1;
    step();
    chk("cmpgt_ex", ex_out, 1);
    chk("cmpgt_taken", branch_taken, 0);
    chk("cmpgt_pred", pred_out, 4'b0010);
    issue(OP_ADD, 32'd0, 32'd0);
    pred_wr_sel = 2;
    step();
    chk("br_taken", branch_taken, 1);
    chk("add_nowr", pred_out, 4'b0010);
    issue(OP_CMPNZ, 32'd5, 32'd0);
    pred_wr_sel = 3; branch_in = 1'b0;
    step();
    chk("cmpnz_ex", ex_out, 1);
    chk("cmpnz_pred", pred_out, 4'b1010);
    issue(OP_CMPNZ, 32'd1, 32'hFFFF_FFFF);
    pred_wr_en = 1'b0;
    step();
    chk("cmpnz0_ex", ex_out, 0);
    chk("cmpnz_noen", pred_out, 4'b1010);
    issue(OP_SUB, 32'd3, 32'd5);
    pred_wr_en = 1'b1; pred_wr_sel = 0;
    step();
    chk("sub_ex", ex_out, 32'hFFFF_FFFE);
    chk("sub_nowr", pred_out, 4'b1010);
    issue(OP_RSVD, 32'd1, 32'd1);
    pred_wr_en = 1'b0;
    step();
    chk("rsvd_ex", ex_out, 0);

    issue(OP_MUL, 32'd7, 32'd6);
    pc_in = 32'h200; imm = 11'h010;
    step();
    in_valid = 1'b0;
    n = 0; nr = 0;
    while (!out_valid && n < 40) begin
      if (!in_ready) nr++;
      step();
      n++;
    end
    chk("mul_lat", n, 33);
    chk("mul_nready", nr, 33);
    chk("mul_ex", ex_out, 32'd42);
    chk("mul_pc", pc_out, 32'h210);

    issue(OP_MUL, 32'd3, 32'd5);
    step();
    in_valid = 1'b0; out_ready = 1'b0;
    repeat (40) step();
    chk("mulh_valid", out_valid, 1);
    chk("mulh_ex", ex_out, 32'd15);
    chk("mulh_ready", in_ready, 0);
    for (int i = 0; i < 3; i++) begin
      step();
      chk("stall_ex", ex_out, 32'd15);
      chk("stall_pc", pc_out, 32'h210);
      chk("stall_ready", in_ready, 0);
    end
    issue(OP_ADD, 32'd10, 32'd20);
    out_ready = 1'b1;
    #1;
    chk("drain_ready", in_ready, 1);
    step();
    chk("drain_valid", out_valid, 1);
    chk("drain_ex", ex_out, 32'd30);

    issue(OP_MUL, 32'd2, 32'd3);
    step();
    in_valid = 1'b0;
    repeat (9) step();
    flush = 1'b1;
    #1;
    chk("flush_ready", in_ready, 0);
    step();
    flush = 1'b0;
    #1;
    chk("flush_valid", out_valid, 0);
    chk("flush_ready1", in_ready, 1);
    chk("flush_pred", pred_out, 4'b1010);
    repeat (40) step();
    chk("flush_stale", out_valid, 0);

    issue(OP_ADD, 32'd1, 32'd1);
    pc_in = 32'h40; imm = 11'h4; branch_in = 1'b1; pred_rd_sel = 1;
    step();
    in_valid = 1'b0;
    chk("pre_rst_ex", ex_out, 32'd2);
    chk("pre_rst_taken", branch_taken, 1);
    #2 rst = 1'b1;
    #1;
    chk("arst_valid", out_valid, 0);
    chk("arst_ex", ex_out, 0);
    chk("arst_pc", pc_out, 0);
    chk("arst_taken", branch_taken, 0);
    chk("arst_pred", pred_out, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
